// File: rtl/riscv_dm_pkg.sv
// Shared debug-module definitions: DMI widths, op encodings, responder state
// and a small address-range helper.
package riscv_dm_pkg;

   localparam int DMI_ADDR_WIDTH = 7;
   localparam int DMI_DATA_WIDTH = 32;
   localparam int DMI_OP_WIDTH   = 2;

   // request op encodings
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ  = 2'd1;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE = 2'd2;

   // response op encodings
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] RD_OP_BUSY    = 2'd3;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_REG_REQ,
      RSP_REG_WAIT,
      RSP_RESP
   } dmi_rsp_state_e;

   // Unsigned inclusive range check. Operands are widened by one bit so a
   // bound at the top of the address space does not fold to a constant
   // comparison.
   function automatic logic dmi_addr_in_range(input logic [DMI_ADDR_WIDTH-1:0] addr,
                                              input logic [DMI_ADDR_WIDTH-1:0] lo,
                                              input logic [DMI_ADDR_WIDTH-1:0] hi);
      logic [DMI_ADDR_WIDTH:0] a, l, h;
      a = {1'b0, addr};
      l = {1'b0, lo};
      h = {1'b0, hi};
      return (a >= l) && (a <= h);
   endfunction

endpackage

// File: rtl/riscv_dmi_responder_if.sv
// Bus bundle for the DMI responder: DMI request/response channels plus the
// register port toward the debug-module register file.
interface riscv_dmi_responder_if;
   import riscv_dm_pkg::*;

   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [DMI_ADDR_WIDTH-1:0] req_addr_i;
   logic [DMI_DATA_WIDTH-1:0] req_data_i;
   logic [DMI_OP_WIDTH-1:0]   req_op_i;

   logic                      resp_valid_o;
   logic                      resp_ready_i;
   logic [DMI_DATA_WIDTH-1:0] resp_data_o;
   logic [DMI_OP_WIDTH-1:0]   resp_op_o;

   logic                      reg_valid_o;
   logic                      reg_ready_i;
   logic                      reg_we_o;
   logic [DMI_ADDR_WIDTH-1:0] reg_addr_o;
   logic [DMI_DATA_WIDTH-1:0] reg_wdata_o;
   logic                      reg_rvalid_i;
   logic [DMI_DATA_WIDTH-1:0] reg_rdata_i;
   logic                      reg_err_i;

   // responder side
   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
             reg_ready_i, reg_rvalid_i, reg_rdata_i, reg_err_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
             reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o
   );

   // transport / register-file side
   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
             reg_ready_i, reg_rvalid_i, reg_rdata_i, reg_err_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_op_o,
             reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o
   );

endinterface

// File: rtl/riscv_dmi_timeout.sv
// Clear/enable/expire counter. Saturates at TIMEOUT_CYCLES; expired_o is
// high while the count sits there. TIMEOUT_CYCLES = 0 never expires.
module riscv_dmi_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // clear wins over count; hold at the limit instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/riscv_dmi_responder.sv
// DM-side DMI endpoint: one request at a time, each answered with exactly
// one response. In-range reads/writes become a single register-port access;
// NOP, reserved ops, out-of-range addresses and timeouts are answered locally.
module riscv_dmi_responder
   import riscv_dm_pkg::*;
#(
   parameter logic [DMI_ADDR_WIDTH-1:0] ADDR_LO        = 7'h04,
   parameter logic [DMI_ADDR_WIDTH-1:0] ADDR_HI        = 7'h7F,
   parameter int unsigned               TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   riscv_dmi_responder_if.slave  bus
);

   dmi_rsp_state_e            state_q, state_d;
   logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DMI_DATA_WIDTH-1:0] data_q, data_d;
   logic [DMI_OP_WIDTH-1:0]   op_q, op_d;
   logic [DMI_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic [DMI_OP_WIDTH-1:0]   resp_op_q, resp_op_d;

   logic tmo_clear, tmo_enable, tmo_expired;

   // Counter runs only while a register access is in flight; it is cleared
   // on the accept that leads into REG_REQ.
   assign tmo_enable = (state_q == RSP_REG_REQ) || (state_q == RSP_REG_WAIT);

   riscv_dmi_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_enable),
      .expired_o (tmo_expired)
   );

   // next-state, latching and response capture
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      op_d        = op_q;
      resp_data_d = resp_data_q;
      resp_op_d   = resp_op_q;
      tmo_clear   = 1'b0;

      case (state_q)
         RSP_IDLE: begin
            if (bus.req_valid_i) begin
               addr_d      = bus.req_addr_i;
               data_d      = bus.req_data_i;
               op_d        = bus.req_op_i;
               resp_data_d = '0;
               if (bus.req_op_i == DMI_OP_NOP) begin
                  resp_op_d = RD_OP_SUCCESS;
                  state_d   = RSP_RESP;
               end else if ((bus.req_op_i != DMI_OP_READ && bus.req_op_i != DMI_OP_WRITE) ||
                            !dmi_addr_in_range(bus.req_addr_i, ADDR_LO, ADDR_HI)) begin
                  resp_op_d = RD_OP_FAILED;
                  state_d   = RSP_RESP;
               end else begin
                  tmo_clear = 1'b1;
                  state_d   = RSP_REG_REQ;
               end
            end
         end
         RSP_REG_REQ: begin
            // completion in the handshake cycle beats a coinciding timeout
            if (bus.reg_ready_i && bus.reg_rvalid_i) begin
               resp_data_d = (op_q == DMI_OP_READ) ? bus.reg_rdata_i : '0;
               resp_op_d   = bus.reg_err_i ? RD_OP_FAILED : RD_OP_SUCCESS;
               state_d     = RSP_RESP;
            end else if (tmo_expired) begin
               resp_data_d = '0;
               resp_op_d   = RD_OP_FAILED;
               state_d     = RSP_RESP;
            end else if (bus.reg_ready_i) begin
               state_d = RSP_REG_WAIT;
            end
         end
         RSP_REG_WAIT: begin
            if (bus.reg_rvalid_i) begin
               resp_data_d = (op_q == DMI_OP_READ) ? bus.reg_rdata_i : '0;
               resp_op_d   = bus.reg_err_i ? RD_OP_FAILED : RD_OP_SUCCESS;
               state_d     = RSP_RESP;
            end else if (tmo_expired) begin
               resp_data_d = '0;
               resp_op_d   = RD_OP_FAILED;
               state_d     = RSP_RESP;
            end
         end
         RSP_RESP: begin
            if (bus.resp_ready_i) begin
               resp_data_d = '0;
               resp_op_d   = RD_OP_SUCCESS;
               state_d     = RSP_IDLE;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   // state and latched transaction registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RSP_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         op_q        <= '0;
         resp_data_q <= '0;
         resp_op_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         op_q        <= op_d;
         resp_data_q <= resp_data_d;
         resp_op_q   <= resp_op_d;
      end
   end

   assign bus.req_ready_o  = (state_q == RSP_IDLE);
   assign bus.resp_valid_o = (state_q == RSP_RESP);
   assign bus.resp_data_o  = resp_data_q;
   assign bus.resp_op_o    = resp_op_q;
   assign bus.reg_valid_o  = (state_q == RSP_REG_REQ);
   assign bus.reg_we_o     = (op_q == DMI_OP_WRITE);
   assign bus.reg_addr_o   = addr_q;
   assign bus.reg_wdata_o  = data_q;

endmodule

// File: tb/tb_riscv_dmi_responder.sv
// Directed bench for riscv_dmi_responder (TIMEOUT_CYCLES = 8).
module tb_riscv_dmi_responder;
   import riscv_dm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   riscv_dmi_responder_if dmi();

   riscv_dmi_responder #(
      .ADDR_LO        (7'h04),
      .ADDR_HI        (7'h7F),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dmi.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // present a request in IDLE; returns just after the accepting edge
   task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
      dmi.req_valid_i = 1'b1;
      dmi.req_op_i    = op;
      dmi.req_addr_i  = addr;
      dmi.req_data_i  = data;
      cyc();
      dmi.req_valid_i = 1'b0;
   endtask

   task automatic resp_hs();
      dmi.resp_ready_i = 1'b1;
      cyc();
      dmi.resp_ready_i = 1'b0;
   endtask

   initial begin
      dmi.req_valid_i  = 1'b0;
      dmi.req_addr_i   = '0;
      dmi.req_data_i   = '0;
      dmi.req_op_i     = '0;
      dmi.resp_ready_i = 1'b0;
      dmi.reg_ready_i  = 1'b0;
      dmi.reg_rvalid_i = 1'b0;
      dmi.reg_rdata_i  = '0;
      dmi.reg_err_i    = 1'b0;

      // reset state
      cyc(); cyc();
      chk("rst_req_ready", 32'(dmi.req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(dmi.resp_valid_o), 32'd0);
      chk("rst_reg_valid", 32'(dmi.reg_valid_o), 32'd0);
      chk("rst_resp_data", dmi.resp_data_o, 32'h0);
      chk("rst_resp_op", 32'(dmi.resp_op_o), 32'd0);
      chk("rst_reg_we", 32'(dmi.reg_we_o), 32'd0);
      chk("rst_reg_addr", 32'(dmi.reg_addr_o), 32'd0);
      chk("rst_reg_wdata", dmi.reg_wdata_o, 32'h0);
      rst = 1'b0;
      cyc();

      // READ 0x04, zero-wait register port: RESP 3 cycles after accept
      dmi.reg_ready_i = 1'b1;
      send(DMI_OP_READ, 7'h04, 32'h0);
      chk("rd_reg_valid", 32'(dmi.reg_valid_o), 32'd1);
      chk("rd_reg_addr", 32'(dmi.reg_addr_o), 32'h04);
      chk("rd_reg_we", 32'(dmi.reg_we_o), 32'd0);
      chk("rd_req_ready_busy", 32'(dmi.req_ready_o), 32'd0);
      cyc();
      dmi.reg_ready_i  = 1'b0;
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_rdata_i  = 32'hDEADBEEF;
      dmi.reg_err_i    = 1'b0;
      chk("rd_wait_no_resp", 32'(dmi.resp_valid_o), 32'd0);
      chk("rd_wait_no_reg_valid", 32'(dmi.reg_valid_o), 32'd0);
      cyc();
      dmi.reg_rvalid_i = 1'b0;
      chk("rd_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("rd_resp_data", dmi.resp_data_o, 32'hDEADBEEF);
      chk("rd_resp_op", 32'(dmi.resp_op_o), 32'd0);
      resp_hs();
      chk("rd_back_idle", 32'(dmi.req_ready_o), 32'd1);
      chk("rd_resp_dropped", 32'(dmi.resp_valid_o), 32'd0);

      // WRITE 0x10 with reg_ready delayed 5 cycles, error completion
      send(DMI_OP_WRITE, 7'h10, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         chk("wr_reg_valid_held", 32'(dmi.reg_valid_o), 32'd1);
         chk("wr_wdata_stable", dmi.reg_wdata_o, 32'h12345678);
         chk("wr_addr_stable", 32'(dmi.reg_addr_o), 32'h10);
         chk("wr_we_stable", 32'(dmi.reg_we_o), 32'd1);
         cyc();
      end
      dmi.reg_ready_i = 1'b1;
      chk("wr_wdata_at_hs", dmi.reg_wdata_o, 32'h12345678);
      cyc();
      dmi.reg_ready_i  = 1'b0;
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_err_i    = 1'b1;
      dmi.reg_rdata_i  = 32'hAAAA5555;
      cyc();
      dmi.reg_rvalid_i = 1'b0;
      dmi.reg_err_i    = 1'b0;
      chk("wr_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("wr_resp_op_failed", 32'(dmi.resp_op_o), 32'd2);
      chk("wr_resp_data_zero", dmi.resp_data_o, 32'h0);
      resp_hs();

      // local responses: reserved op, below ADDR_LO, NOP
      send(2'd3, 7'h10, 32'h0);
      chk("rsv_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("rsv_resp_op", 32'(dmi.resp_op_o), 32'd2);
      chk("rsv_resp_data", dmi.resp_data_o, 32'h0);
      chk("rsv_no_reg", 32'(dmi.reg_valid_o), 32'd0);
      resp_hs();
      send(DMI_OP_READ, 7'h02, 32'h0);
      chk("oor_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("oor_resp_op", 32'(dmi.resp_op_o), 32'd2);
      chk("oor_no_reg", 32'(dmi.reg_valid_o), 32'd0);
      resp_hs();
      send(DMI_OP_NOP, 7'h10, 32'hFFFFFFFF);
      chk("nop_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("nop_resp_op", 32'(dmi.resp_op_o), 32'd0);
      chk("nop_resp_data", dmi.resp_data_o, 32'h0);
      chk("nop_no_reg", 32'(dmi.reg_valid_o), 32'd0);
      resp_hs();

      // timeout: reg_ready held low, count 0..8 then abort
      send(DMI_OP_READ, 7'h20, 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("to_reg_valid_held", 32'(dmi.reg_valid_o), 32'd1);
         chk("to_no_resp_yet", 32'(dmi.resp_valid_o), 32'd0);
         cyc();
      end
      chk("to_last_req_cycle", 32'(dmi.reg_valid_o), 32'd1);
      cyc();
      chk("to_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("to_resp_op", 32'(dmi.resp_op_o), 32'd2);
      chk("to_resp_data", dmi.resp_data_o, 32'h0);
      chk("to_reg_valid_drop", 32'(dmi.reg_valid_o), 32'd0);
      resp_hs();
      // late completion in IDLE must be ignored
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_rdata_i  = 32'h0BAD0BAD;
      dmi.reg_err_i    = 1'b1;
      cyc();
      dmi.reg_rvalid_i = 1'b0;
      dmi.reg_err_i    = 1'b0;
      chk("late_rvalid_ignored", 32'(dmi.resp_valid_o), 32'd0);
      chk("late_rvalid_idle", 32'(dmi.req_ready_o), 32'd1);
      // next READ at ADDR_HI, rvalid coinciding with ready: RESP after 2 cycles
      dmi.reg_ready_i = 1'b1;
      send(DMI_OP_READ, 7'h7F, 32'h0);
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_rdata_i  = 32'hCAFEF00D;
      chk("hi_reg_valid", 32'(dmi.reg_valid_o), 32'd1);
      cyc();
      dmi.reg_ready_i  = 1'b0;
      dmi.reg_rvalid_i = 1'b0;
      chk("same_cyc_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
      chk("same_cyc_resp_data", dmi.resp_data_o, 32'hCAFEF00D);
      chk("same_cyc_resp_op", 32'(dmi.resp_op_o), 32'd0);
      resp_hs();

      // response backpressure with a new request waiting
      dmi.reg_ready_i = 1'b1;
      send(DMI_OP_READ, 7'h08, 32'h0);
      cyc();
      dmi.reg_ready_i  = 1'b0;
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_rdata_i  = 32'h11112222;
      cyc();
      dmi.reg_rvalid_i = 1'b0;
      dmi.req_valid_i  = 1'b1;
      dmi.req_op_i     = DMI_OP_NOP;
      dmi.req_addr_i   = 7'h00;
      for (int i = 0; i < 10; i++) begin
         chk("bp_resp_valid", 32'(dmi.resp_valid_o), 32'd1);
         chk("bp_resp_data", dmi.resp_data_o, 32'h11112222);
         chk("bp_resp_op", 32'(dmi.resp_op_o), 32'd0);
         chk("bp_req_ready_low", 32'(dmi.req_ready_o), 32'd0);
         cyc();
      end
      dmi.resp_ready_i = 1'b1;
      cyc();
      dmi.resp_ready_i = 1'b0;
      chk("bp_idle_after_hs", 32'(dmi.req_ready_o), 32'd1);
      cyc();
      dmi.req_valid_i = 1'b0;
      chk("bp_new_accepted", 32'(dmi.resp_valid_o), 32'd1);
      chk("bp_new_op", 32'(dmi.resp_op_o), 32'd0);
      resp_hs();

      // reset during REG_WAIT
      dmi.reg_ready_i = 1'b1;
      send(DMI_OP_READ, 7'h40, 32'h0);
      cyc();
      dmi.reg_ready_i = 1'b0;
      chk("rw_addr_before_rst", 32'(dmi.reg_addr_o), 32'h40);
      rst = 1'b1;
      #1;
      chk("arst_req_ready", 32'(dmi.req_ready_o), 32'd1);
      chk("arst_resp_valid", 32'(dmi.resp_valid_o), 32'd0);
      chk("arst_reg_valid", 32'(dmi.reg_valid_o), 32'd0);
      chk("arst_reg_addr", 32'(dmi.reg_addr_o), 32'd0);
      chk("arst_reg_we", 32'(dmi.reg_we_o), 32'd0);
      cyc();
      rst = 1'b0;
      dmi.reg_rvalid_i = 1'b1;
      dmi.reg_rdata_i  = 32'h55555555;
      cyc();
      dmi.reg_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_resp", 32'(dmi.resp_valid_o), 32'd0);
         chk("post_rst_ready", 32'(dmi.req_ready_o), 32'd1);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_dmi_responder.md
Name: riscv_dmi_responder

Overview:
- DM-side terminating endpoint of the DMI link: accepts one DMI request at a time on the req valid/ready channel and returns exactly one response on the resp valid/ready channel.
- Reads and writes are converted into single accesses on a simple register port toward the debug-module register file.
- Handles NOP, reserved ops, out-of-range addresses and register-port timeout locally, so every accepted request completes.
- Sits between the DMI transport (DTM or CDC stage) and the DM core, in the DM clock domain.

Parameters:
- ADDR_LO, 7'h04: lowest DMI address forwarded to the register port.
- ADDR_HI, 7'h7F: highest DMI address forwarded to the register port.
- TIMEOUT_CYCLES, 255: cycles allowed in REG_REQ+REG_WAIT before a FAILED response; 0 disables the timeout.

Ports:
- clk_i  in  1  DM clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  DMI request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  DMI_ADDR_WIDTH  request address
- req_data_i  in  DMI_DATA_WIDTH  write data
- req_op_i  in  DMI_OP_WIDTH  0 NOP, 1 READ, 2 WRITE, 3 reserved
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&ready
- resp_data_o  out  DMI_DATA_WIDTH  read data
- resp_op_o  out  DMI_OP_WIDTH  0 SUCCESS, 2 FAILED
- reg_valid_o  out  1  register access request
- reg_ready_i  in  1  register access accepted
- reg_we_o  out  1  1 = write
- reg_addr_o  out  DMI_ADDR_WIDTH  register address
- reg_wdata_o  out  DMI_DATA_WIDTH  register write data
- reg_rvalid_i  in  1  single-cycle completion pulse, no backpressure
- reg_rdata_i  in  DMI_DATA_WIDTH  read data, valid with reg_rvalid_i
- reg_err_i  in  1  access error, valid with reg_rvalid_i

Behaviour:
- Reset: state IDLE; all outputs 0, except req_ready_o = 1 (IDLE); latched addr/data/op/resp registers and timeout counter 0.
- One transaction outstanding at a time. req_ready_o = 1 only in IDLE.
- IDLE: on req_valid_i&req_ready_o, latch addr, data and op.
  - NOP -> RESP with SUCCESS, data 0.
  - Reserved op, or addr outside [ADDR_LO, ADDR_HI] -> RESP with FAILED, data 0, and no register access.
  - READ or WRITE in range -> REG_REQ.
- REG_REQ: reg_valid_o = 1; reg_addr_o, reg_we_o and reg_wdata_o come from latched registers and stay stable until reg_ready_i. On reg_valid_o&reg_ready_i -> REG_WAIT.
- REG_WAIT: on reg_rvalid_i:
  - resp_data_o <= reg_rdata_i for READ; 0 for WRITE.
  - resp_op_o <= FAILED if reg_err_i, else SUCCESS.
  - -> RESP.
- A reg_rvalid_i in the same cycle as the reg_ready_i handshake is legal: go directly to RESP and capture as in REG_WAIT.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter clears on entry to REG_REQ and increments each cycle in REG_REQ and REG_WAIT.
  - When the counter reaches TIMEOUT_CYCLES and there is no completion that cycle -> RESP with FAILED, data 0; reg_valid_o is withdrawn (abort).
  - If completion and timeout coincide, the completion wins.
- reg_rvalid_i outside REG_WAIT (and outside the same-cycle case) is ignored, e.g. late completions after timeout.
- RESP: resp_valid_o = 1; resp_data_o and resp_op_o stay stable until resp_ready_i. On handshake -> IDLE; a new request can be accepted the following cycle.
- Latency:
  - Local response (NOP, illegal op, out of range): resp_valid_o rises 1 cycle after the accept.
  - Forwarded access with zero-wait register port: accept -> REG_REQ -> REG_WAIT -> RESP gives resp_valid_o 3 cycles after the accept (2 if rvalid coincides with ready).
- Address compare is unsigned on DMI_ADDR_WIDTH bits. Counter width is $clog2(TIMEOUT_CYCLES+1), with no wrap.
- rst_i asserted mid-transaction aborts immediately: all outputs drop to reset values and any pending response is lost.

Decomposition:
- Add to riscv_dm_pkg:
  - request op constants DMI_OP_NOP, DMI_OP_READ, DMI_OP_WRITE;
  - RD_OP_FAILED next to the existing RD_OP_SUCCESS and RD_OP_BUSY;
  - the responder state enum typedef.
- Reuse DMI_ADDR_WIDTH, DMI_DATA_WIDTH and DMI_OP_WIDTH from the package.
- One sub-module: riscv_dmi_timeout (clear/enable/expire counter parameterised by TIMEOUT_CYCLES). It is reusable by other DM blocks.

Test Plan:
- Stimulus: READ addr 0x04, reg port returns rdata 0xDEADBEEF, err 0, zero wait. Required: resp_data 0xDEADBEEF, op 0, resp_valid 3 cycles after accept; reg_we 0.
- Stimulus: WRITE addr 0x10, data 0x12345678, reg_ready delayed 5 cycles, rvalid with err=1. Required: reg_wdata stable for all 5 cycles; resp op 2, data 0.
- Stimulus: op 3, then READ addr 0x02 with ADDR_LO = 0x04, then NOP. Required: each gives resp_valid 1 cycle after accept, with op 2, 2 and 0 respectively; reg_valid never asserted.
- Stimulus: TIMEOUT_CYCLES = 8, reg_ready held 0. Required: FAILED response after the counter reaches 8; reg_valid drops; a later spurious reg_rvalid is ignored; the next READ completes normally.
- Stimulus: resp_ready held 0 for 10 cycles, with req_valid held high carrying a new request. Required: response data/op stable; req_ready 0 throughout; new request accepted the cycle after the resp handshake.
- Stimulus: rst_i pulsed during REG_WAIT. Required: all outputs return to reset values asynchronously; req_ready 1 after release; no response emitted for the aborted request.
